// File: rtl/snn_pkg.sv
// snn_pkg: shared class count, no-spike digit code and sequencer state type
package snn_pkg;
  localparam int NUM_CLASSES = 10;
  localparam logic [3:0] NO_SPIKE_DIGIT = 4'hF;
  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;
endpackage

// File: rtl/inference_sequencer_if.sv
// inference_sequencer_if: start/spike/result handshake bundle; slave = sequencer side (start_i, spike_valid_i, spike_i, result_ready_i in; busy_o, result_valid_o, result_digit_o, result_count_o out)
interface inference_sequencer_if import snn_pkg::*; #(parameter int CNT_W = 8);
  logic start_i;
  logic busy_o;
  logic spike_valid_i;
  logic [NUM_CLASSES-1:0] spike_i;
  logic result_valid_o;
  logic result_ready_i;
  logic [3:0] result_digit_o;
  logic [CNT_W-1:0] result_count_o;
  modport slave (input start_i, spike_valid_i, spike_i, result_ready_i, output busy_o, result_valid_o, result_digit_o, result_count_o);
  modport master (output start_i, spike_valid_i, spike_i, result_ready_i, input busy_o, result_valid_o, result_digit_o, result_count_o);
endinterface

// File: rtl/spike_counter_bank.sv
// spike_counter_bank: ten saturating per-class spike counters; clk/rst, clr zeroes all, inc bit k bumps counter k, rd returns counter sel (0 when sel>9)
module spike_counter_bank import snn_pkg::*; #(parameter int CNT_W = 8) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [NUM_CLASSES-1:0] inc,
  input  logic [3:0]             sel,
  output logic [CNT_W-1:0]       rd
);
  logic [CNT_W-1:0] cnt [NUM_CLASSES];
  always_ff @(posedge clk)
    for (int k = 0; k < NUM_CLASSES; k++)
      if (rst || clr) cnt[k] <= '0;
      else if (inc[k] && cnt[k] != '1) cnt[k] <= cnt[k] + 1'b1;
  assign rd = sel < 4'(NUM_CLASSES) ? cnt[sel] : '0;
endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: counts class spikes over NUM_STEPS valid timesteps, then argmax-scans one class per cycle and holds the result until accepted; clk_i, rst_i, bus (slave)
module inference_sequencer import snn_pkg::*; #(
  parameter int NUM_STEPS = 100,
  parameter int CNT_W     = 8
) (
  input logic clk_i,
  input logic rst_i,
  inference_sequencer_if.slave bus
);
  localparam int SW = $clog2(NUM_STEPS + 1);
  state_t state;
  logic [SW-1:0] step;
  logic [3:0] idx, max_idx, nidx;
  logic [CNT_W-1:0] max_cnt, rd_cnt, nmax;
  logic [NUM_CLASSES-1:0] inc;
  logic clr, upd;
  always_comb begin
    upd  = rd_cnt > max_cnt;
    nmax = upd ? rd_cnt : max_cnt;
    nidx = upd ? idx : max_idx;
    clr  = state == IDLE && bus.start_i;
    inc  = (state == ACCUM && bus.spike_valid_i) ? bus.spike_i : '0;
  end
  spike_counter_bank #(.CNT_W(CNT_W)) u_bank (
    .clk(clk_i), .rst(rst_i), .clr(clr), .inc(inc), .sel(idx), .rd(rd_cnt)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      step <= '0;
      idx <= '0;
      max_idx <= NO_SPIKE_DIGIT;
      max_cnt <= '0;
      bus.busy_o <= 1'b0;
      bus.result_valid_o <= 1'b0;
      bus.result_digit_o <= NO_SPIKE_DIGIT;
      bus.result_count_o <= '0;
    end else case (state)
      IDLE: if (bus.start_i) begin
        state <= ACCUM;
        bus.busy_o <= 1'b1;
        step <= '0;
        idx <= '0;
        max_idx <= NO_SPIKE_DIGIT;
        max_cnt <= '0;
      end
      ACCUM: if (bus.spike_valid_i) begin
        step <= step + 1'b1;
        if (step == SW'(NUM_STEPS - 1)) state <= SCAN;
      end
      SCAN: begin
        max_cnt <= nmax;
        max_idx <= nidx;
        idx <= idx + 1'b1;
        if (idx == 4'(NUM_CLASSES - 1)) begin
          state <= DONE;
          bus.result_valid_o <= 1'b1;
          bus.result_digit_o <= nidx;
          bus.result_count_o <= nmax;
        end
      end
      DONE: if (bus.result_ready_i) begin
        state <= IDLE;
        bus.busy_o <= 1'b0;
        bus.result_valid_o <= 1'b0;
      end
    endcase
endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 100, the number of timesteps per inference window (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 8, the per-class spike counter width.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit, a request to begin an inference window.
REQ-006 SHALL have port busy_o, output, 1 bit, high in every state except IDLE.
REQ-007 SHALL have port spike_valid_i, input, 1 bit; each high cycle in ACCUM is one timestep.
REQ-008 SHALL have port spike_i, input, 10 bits, the output-neuron spikes for the current timestep, bit k = class k.
REQ-009 SHALL have port result_valid_o, output, 1 bit, meaning the result is held stable.
REQ-010 SHALL have port result_ready_i, input, 1 bit, the consumer's acceptance of the result.
REQ-011 SHALL have port result_digit_o, output, 4 bits, the winning class 0..9, or 4'hF when no class spiked.
REQ-012 SHALL have port result_count_o, output, CNT_W bits, the winning class's spike count.

Function
REQ-013 SHALL implement states IDLE, ACCUM, SCAN and DONE.
REQ-014 SHALL, in IDLE with start_i=1, clear all 10 counters and the step counter and enter ACCUM on the next cycle.
REQ-015 SHALL ignore start_i in every state except IDLE, with no restart and no error.
REQ-016 SHALL, in ACCUM, on each cycle with spike_valid_i=1, increment counter k for every set bit spike_i[k] and increment the step counter.
REQ-017 SHALL make counters saturate at 2^CNT_W-1 with no wrap.
REQ-018 SHALL ignore cycles with spike_valid_i=0 in ACCUM: no count change and no step increment.
REQ-019 SHALL ignore spike_valid_i and spike_i outside ACCUM.
REQ-020 SHALL, when the NUM_STEPS-th timestep is accepted at cycle T, count that timestep's spikes and be in SCAN at T+1.
REQ-021 SHALL, in SCAN, examine one class per cycle, indices 0..9 in order on cycles T+1..T+10, keeping a running max and its index.
REQ-022 SHALL replace the running max only when count > max (strict), so ties resolve to the lowest index.
REQ-023 SHALL initialise the running max to 0 and its index to 4'hF, so all-zero counts yield digit 4'hF with count 0.
REQ-024 SHALL enter DONE at T+11 with result_valid_o=1 and the registered result_digit_o and result_count_o.
REQ-025 SHALL hold result_valid_o, result_digit_o and result_count_o stable in DONE until result_ready_i=1.
REQ-026 SHALL, on result_valid_o and result_ready_i both high, complete the handshake and return to IDLE on the next cycle.
REQ-027 SHALL leave result_digit_o and result_count_o holding their last values in IDLE, with result_valid_o=0.
REQ-028 SHALL make result_ready_i have no effect outside DONE.
REQ-029 SHALL make the step counter width $clog2(NUM_STEPS+1).

Reset
REQ-030 SHALL, on rst_i=1 at a clock edge, enter IDLE and clear all counters, the step counter and the running max, set the scan index to 0 and the running-max index to 4'hF, and drive busy_o=0, result_valid_o=0, result_digit_o=4'hF and result_count_o=0.
REQ-031 SHALL let reset take priority over every other input in any state, including mid-ACCUM, mid-SCAN and DONE, and discard the pending result.

Structure
REQ-032 SHALL place NUM_CLASSES=10, NO_SPIKE_DIGIT=4'hF and the state enum type in the shared package snn_pkg.
REQ-033 SHALL contain one sub-module, spike_counter_bank, holding the 10 saturating counters with clear, increment-vector and read-by-index ports.
REQ-034 SHALL keep the FSM, step counter and argmax scan in inference_sequencer.

Verification
REQ-035 SHALL cover: NUM_STEPS=4, spike_i=10'h004 on each of 4 consecutive steps -> digit 2, count 4, result_valid_o rising 11 cycles after the 4th step.
REQ-036 SHALL cover: class 3 and class 7 each spiking 5 times -> digit 3, count 5 (lowest index wins the tie).
REQ-037 SHALL cover: spike_i=0 for all steps -> digit 4'hF, count 0.
REQ-038 SHALL cover: NUM_STEPS=300, class 9 spiking every step -> count 255 (saturated), digit 9.
REQ-039 SHALL cover: spike_valid_i gapped 1-of-3 cycles and start_i pulsed during ACCUM -> window ends after exactly NUM_STEPS valid cycles, no restart.
REQ-040 SHALL cover: result_ready_i held low 20 cycles in DONE, then rst_i asserted mid-SCAN of a second run -> outputs stable while held, then reset values the next cycle.
